// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the register-file debug read-out path:
// state encoding, default widths and the hard-wired zero register number.
package mips_dbg_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        SEND  = ST_SEND
    } state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/mips_reg_dump.sv
// Walks an inclusive, wrap-around register range over one register-file read
// port and hands each captured word to a consumer via a valid/ready handshake.
module mips_reg_dump
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] First_Addr,
    input  logic [ADDR_W-1:0] Last_Addr,
    output logic [ADDR_W-1:0] R_Addr,
    input  logic [DATA_W-1:0] R_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [ADDR_W-1:0] Out_Addr,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Busy,
    output logic              Done
);

    state_t              state_q;
    logic [ADDR_W-1:0]   cur_q;
    logic [ADDR_W-1:0]   last_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                done_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        cur_q   <= First_Addr;
                        last_q  <= Last_Addr;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (Abort) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_data_q  <= R_Data;
                        out_addr_q  <= cur_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    // Abort wins over a coincident handshake: the word is dropped.
                    if (Abort) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (Out_Ready) begin
                        out_valid_q <= 1'b0;
                        if (cur_q == last_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cur_q   <= cur_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign R_Addr    = (state_q == IDLE) ? ADDR_W'(REG_ZERO) : cur_q;
    assign Busy      = (state_q == FETCH) || (state_q == SEND);
    assign Out_Valid = out_valid_q;
    assign Out_Addr  = out_addr_q;
    assign Out_Data  = out_data_q;
    assign Done      = done_q;

endmodule
